// File: rtl/median9_pipe_sorter.sv
// median9_pipe_sorter: 3-stage pipelined 3x3 rank filter.
// Row sorts -> column reduction -> median-of-3 / min / max / centre select.
// Compare-and-select only, so every result is one of the input pixels.

module median9_sort3 #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] mn,
  output logic [WIDTH-1:0] md,
  output logic [WIDTH-1:0] mx
);
  function automatic logic lt(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (SIGNED != 0) return $signed(x) < $signed(y);
    else             return x < y;
  endfunction

  logic [WIDTH-1:0] lo_ab, hi_ab;

  // Order a/b, then slot c below, between or above that pair.
  always_comb begin
    lo_ab = lt(b, a) ? b : a;
    hi_ab = lt(b, a) ? a : b;
    mn    = lt(c, lo_ab) ? c : lo_ab;
    mx    = lt(hi_ab, c) ? c : hi_ab;
    md    = lt(c, lo_ab) ? lo_ab : (lt(hi_ab, c) ? hi_ab : c);
  end
endmodule

module median9_pipe_sorter #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [1:0]         in_mode,
  input  logic [9*WIDTH-1:0] in_pix,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_pix,
  output logic [1:0]         out_mode
);
  localparam int STAGES = 3;

  function automatic logic lt(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (SIGNED != 0) return $signed(x) < $signed(y);
    else             return x < y;
  endfunction
  function automatic logic [WIDTH-1:0] min2(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return lt(y, x) ? y : x;
  endfunction
  function automatic logic [WIDTH-1:0] max2(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return lt(x, y) ? y : x;
  endfunction
  function automatic logic [WIDTH-1:0] med3(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic [WIDTH-1:0] z);
    return max2(min2(x, y), min2(max2(x, y), z));
  endfunction

  logic [STAGES:1]         vld_pipe_d, vld_pipe_q;
  logic [2:0][WIDTH-1:0]   rmin_d, rmid_d, rmax_d;
  logic [2:0][WIDTH-1:0]   rmin_q, rmid_q, rmax_q;
  logic [1:0]              mode1_d, mode1_q, mode2_d, mode2_q, out_mode_d, out_mode_q;
  logic [WIDTH-1:0]        ctr1_d, ctr1_q, ctr2_d, ctr2_q;
  logic [WIDTH-1:0]        lo_d, lo_q, md_d, md_q, hi_d, hi_q;
  logic [WIDTH-1:0]        gmin_d, gmin_q, gmax_d, gmax_q;
  logic [WIDTH-1:0]        out_pix_d, out_pix_q;

  // Stage 1 datapath: one sorter per window row.
  for (genvar r = 0; r < 3; r++) begin : g_row
    median9_sort3 #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_sort (
      .a  (in_pix[(3*r)*WIDTH   +: WIDTH]),
      .b  (in_pix[(3*r+1)*WIDTH +: WIDTH]),
      .c  (in_pix[(3*r+2)*WIDTH +: WIDTH]),
      .mn (rmin_d[r]),
      .md (rmid_d[r]),
      .mx (rmax_d[r])
    );
  end

  // Valid shift register and sideband (mode, centre) travelling with the data.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
    mode1_d    = in_mode;
    ctr1_d     = in_pix[4*WIDTH +: WIDTH];
    mode2_d    = mode1_q;
    ctr2_d     = ctr1_q;
    out_mode_d = mode2_q;
  end

  // Stage 2: column reduction; median of 9 = med(max of mins, med of mids, min of maxes).
  always_comb begin
    lo_d   = max2(max2(rmin_q[0], rmin_q[1]), rmin_q[2]);
    md_d   = med3(rmid_q[0], rmid_q[1], rmid_q[2]);
    hi_d   = min2(min2(rmax_q[0], rmax_q[1]), rmax_q[2]);
    gmin_d = min2(min2(rmin_q[0], rmin_q[1]), rmin_q[2]);
    gmax_d = max2(max2(rmax_q[0], rmax_q[1]), rmax_q[2]);
  end

  // Stage 3: per-sample result select.
  always_comb begin
    out_pix_d = ctr2_q;
    case (mode2_q)
      2'b00:   out_pix_d = med3(lo_q, md_q, hi_q);
      2'b01:   out_pix_d = gmin_q;
      2'b10:   out_pix_d = gmax_q;
      default: out_pix_d = ctr2_q;
    endcase
  end

  // All pipeline registers advance together on ce; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      rmin_q     <= '0;
      rmid_q     <= '0;
      rmax_q     <= '0;
      mode1_q    <= '0;
      ctr1_q     <= '0;
      mode2_q    <= '0;
      ctr2_q     <= '0;
      lo_q       <= '0;
      md_q       <= '0;
      hi_q       <= '0;
      gmin_q     <= '0;
      gmax_q     <= '0;
      out_pix_q  <= '0;
      out_mode_q <= '0;
    end else if (ce) begin
      vld_pipe_q <= vld_pipe_d;
      rmin_q     <= rmin_d;
      rmid_q     <= rmid_d;
      rmax_q     <= rmax_d;
      mode1_q    <= mode1_d;
      ctr1_q     <= ctr1_d;
      mode2_q    <= mode2_d;
      ctr2_q     <= ctr2_d;
      lo_q       <= lo_d;
      md_q       <= md_d;
      hi_q       <= hi_d;
      gmin_q     <= gmin_d;
      gmax_q     <= gmax_d;
      out_pix_q  <= out_pix_d;
      out_mode_q <= out_mode_d;
    end
  end

  assign out_valid = vld_pipe_q[STAGES];
  assign out_pix   = out_pix_q;
  assign out_mode  = out_mode_q;
endmodule

// File: tb/tb_median9_pipe_sorter.sv
// Directed bench for median9_pipe_sorter: unsigned and signed instances share stimulus.
module tb_median9_pipe_sorter;
  logic        clk, rst_n, ce, in_valid;
  logic [1:0]  in_mode;
  logic [71:0] in_pix;
  logic        ov_u, ov_s;
  logic [7:0]  op_u, op_s;
  logic [1:0]  om_u, om_s;
  int pass_cnt = 0;
  int tot_cnt  = 0;

  median9_pipe_sorter #(.WIDTH(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_mode(in_mode),
    .in_pix(in_pix), .out_valid(ov_u), .out_pix(op_u), .out_mode(om_u));
  median9_pipe_sorter #(.WIDTH(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_mode(in_mode),
    .in_pix(in_pix), .out_valid(ov_s), .out_pix(op_s), .out_mode(om_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] pk(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                                     input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                                     input logic [7:0] p6, input logic [7:0] p7, input logic [7:0] p8);
    return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  // Software reference: full sort of the nine unsigned pixels.
  function automatic logic [7:0] med_ref(input logic [71:0] p);
    logic [7:0] v [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) v[i] = p[i*8 +: 8];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_pix = '0;
    #2;
    tot_cnt++; if (ov_u !== 1'b0) $display("FAIL reset_valid_u got %b want 0", ov_u); else pass_cnt++;
    tot_cnt++; if (op_u !== 8'd0) $display("FAIL reset_pix_u got %0d want 0", op_u); else pass_cnt++;
    tot_cnt++; if (om_u !== 2'd0) $display("FAIL reset_mode_u got %0d want 0", om_u); else pass_cnt++;
    tot_cnt++; if (ov_s !== 1'b0) $display("FAIL reset_valid_s got %b want 0", ov_s); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_median();
    in_pix = pk(10, 200, 30, 40, 50, 60, 70, 80, 90); in_mode = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tot_cnt++;
      if (ov_u !== (e == 3)) $display("FAIL median_valid_edge%0d got %b want %b", e, ov_u, (e == 3));
      else pass_cnt++;
      if (e == 3) begin
        tot_cnt++; if (op_u !== 8'd60) $display("FAIL median_pix got %0d want 60", op_u); else pass_cnt++;
        tot_cnt++; if (om_u !== 2'b00) $display("FAIL median_mode got %0d want 0", om_u); else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_mode_sweep();
    logic [7:0] exp_sw [4];
    exp_sw = '{8'd60, 8'd10, 8'd200, 8'd50};
    in_pix = pk(10, 200, 30, 40, 50, 60, 70, 80, 90);
    for (int i = 0; i < 7; i++) begin
      in_valid = (i < 4);
      in_mode  = 2'(i);
      tick();
      if (i >= 2 && i <= 5) begin
        tot_cnt++;
        if (ov_u !== 1'b1 || op_u !== exp_sw[i-2] || om_u !== 2'(i-2))
          $display("FAIL sweep_mode%0d got v=%b pix=%0d mode=%0d want v=1 pix=%0d mode=%0d",
                   i-2, ov_u, op_u, om_u, exp_sw[i-2], i-2);
        else pass_cnt++;
      end else if (i == 6) begin
        tot_cnt++; if (ov_u !== 1'b0) $display("FAIL sweep_tail_valid got %b want 0", ov_u); else pass_cnt++;
      end
    end
  endtask

  task automatic test_ties_extremes();
    logic [71:0] tp [3];
    logic [1:0]  tm [3];
    logic [7:0]  te [3];
    tp[0] = pk(7, 7, 7, 7, 7, 7, 7, 7, 7);               tm[0] = 2'b00; te[0] = 8'd7;
    tp[1] = pk(255, 255, 255, 255, 0, 0, 0, 0, 255);     tm[1] = 2'b00; te[1] = 8'd255;
    tp[2] = tp[1];                                       tm[2] = 2'b01; te[2] = 8'd0;
    for (int t = 0; t < 3; t++) begin
      in_pix = tp[t]; in_mode = tm[t]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      tot_cnt++;
      if (ov_u !== 1'b1 || op_u !== te[t])
        $display("FAIL ties_case%0d got v=%b pix=%0d want v=1 pix=%0d", t, ov_u, op_u, te[t]);
      else pass_cnt++;
    end
  endtask

  task automatic test_signed();
    logic [7:0] se [3];
    se = '{8'h00, 8'h80, 8'h7F};
    // -5,3,-128,127,0,-1,2,-2,1
    in_pix = pk(8'hFB, 8'h03, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h02, 8'hFE, 8'h01);
    for (int m = 0; m < 3; m++) begin
      in_mode = 2'(m); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      tot_cnt++;
      if (ov_s !== 1'b1 || op_s !== se[m] || om_s !== 2'(m))
        $display("FAIL signed_mode%0d got v=%b pix=%h mode=%0d want v=1 pix=%h mode=%0d",
                 m, ov_s, op_s, om_s, se[m], m);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    logic [71:0] sp [5];
    logic [7:0]  ex [5];
    logic [7:0]  got [$];
    int k;
    for (int i = 0; i < 5; i++) begin
      sp[i] = {$urandom, $urandom, $urandom};
      ex[i] = med_ref(sp[i]);
    end
    k = 0;
    in_mode = 2'b00;
    for (int cyc = 0; cyc < 14; cyc++) begin
      logic stall;
      stall = (cyc >= 3 && cyc < 7);
      ce = !stall;
      if (k < 5) begin in_valid = 1'b1; in_pix = sp[k]; end
      else in_valid = 1'b0;
      tick();
      if (!stall) begin
        if (k < 5) k++;
        if (ov_u === 1'b1) got.push_back(op_u);
      end else begin
        tot_cnt++;
        if (ov_u !== 1'b1 || op_u !== ex[0])
          $display("FAIL stall_frozen_cyc%0d got v=%b pix=%0d want v=1 pix=%0d", cyc, ov_u, op_u, ex[0]);
        else pass_cnt++;
      end
    end
    ce = 1'b1;
    tot_cnt++;
    if (got.size() != 5) $display("FAIL stall_count got %0d want 5", got.size()); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tot_cnt++;
      if (i >= got.size()) $display("FAIL stall_result%0d got none want %0d", i, ex[i]);
      else if (got[i] !== ex[i]) $display("FAIL stall_result%0d got %0d want %0d", i, got[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    in_pix = pk(10, 200, 30, 40, 50, 60, 70, 80, 90); in_mode = 2'b10; in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    tot_cnt++;
    if (ov_u !== 1'b1 || op_u !== 8'd200) $display("FAIL rstmid_pre got v=%b pix=%0d want v=1 pix=200", ov_u, op_u);
    else pass_cnt++;
    #3 rst_n = 1'b0;
    #1;
    tot_cnt++;
    if (ov_u !== 1'b0 || op_u !== 8'd0 || om_u !== 2'd0)
      $display("FAIL rstmid_async got v=%b pix=%0d mode=%0d want 0 0 0", ov_u, op_u, om_u);
    else pass_cnt++;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tot_cnt++; if (ov_u !== 1'b0) $display("FAIL rstmid_stale%0d got %b want 0", i, ov_u); else pass_cnt++;
    end
    in_mode = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      if (e < 3) begin
        tot_cnt++; if (ov_u !== 1'b0) $display("FAIL rstmid_lat_edge%0d got %b want 0", e, ov_u); else pass_cnt++;
        tick();
      end else begin
        tot_cnt++;
        if (ov_u !== 1'b1 || op_u !== 8'd60) $display("FAIL rstmid_new got v=%b pix=%0d want v=1 pix=60", ov_u, op_u);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_median();
    test_mode_sweep();
    test_ties_extremes();
    test_signed();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
